serpent_ks_seq: RTL and testbench
=================================

Name: serpent_ks_seq

Overview:
- Iterative, one-word-per-cycle Serpent key-schedule sequencer.
- Replaces the flat combinational expansion with an 8-word sliding prekey window, one shared ROL/XOR stage and one bitslice S-box stage.
- Streams the 33 128-bit round subkeys into the external subkey RAM read by the round engine.
- Provides start/busy/done sequencing for the XTS top level.

Parameters:
- SK_COUNT, 33, number of subkeys generated; prekey count = 4*SK_COUNT.
- PHI, 32'h9e3779b9, golden-ratio constant XORed into every prekey.
- ROT, 11, left-rotate amount applied to each prekey.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request; sampled only in IDLE
- i_key  in  256  user key, LSB-aligned
- i_key_len  in  2  0=128b, 1=192b, 2=256b, 3=reserved (treated as 256b)
- i_clear  in  1  synchronous: invalidate keys, abort to IDLE
- o_busy  out  1  high while generating
- o_done  out  1  one-cycle pulse after last subkey written
- o_keys_valid  out  1  level; subkey RAM holds a complete schedule
- o_sk_we  out  1  subkey RAM write strobe
- o_sk_addr  out  6  subkey index 0..32
- o_sk_data  out  128  subkey {word3,word2,word1,word0}

Behaviour:
- Reset (async, i_rst_n low): state IDLE; window, counter and all outputs are 0.
- Clock and reset are fixed as above: single clock i_clk; reset i_rst_n is asynchronous and active-low.
- States: IDLE, GEN, DONE.
- IDLE -> GEN on i_start at edge E0. At E0:
  - Latch padded key into window as w[-8..-1]; w[-8]=key[31:0] ... w[-1]=key[255:224].
  - Padding for keys shorter than 256 bits: bit at position keylen set to 1, all higher bits 0; bits above keylen in i_key ignored.
  - Counter i=0; o_busy=1; o_keys_valid=0.
- GEN, each cycle:
  - w_i = ROL(w_{i-8}^w_{i-5}^w_{i-3}^w_{i-1}^PHI^i, ROT); i is a zero-extended 8-bit counter.
  - Window shifts by one; w_i is registered at edge E(i+1).
- Subkey k is formed from w_{4k..4k+3} once w_{4k+3} is registered:
  - For each bit j in 0..31, nibble n={w_{4k+3}[j],w_{4k+2}[j],w_{4k+1}[j],w_{4k}[j]}, LSB=w_{4k}.
  - Apply S-box S_((3-k) mod 8) from the Serpent standard tables; output bits 0..3 go to subkey word0..word3 bit j.
  - Example: S0 = 3,8,15,1,10,6,5,11,14,13,4,2,7,0,9,12.
- Write timing: o_sk_we=1, o_sk_addr=k, o_sk_data=K_k are registered at edge E(4k+5), one cycle wide. Exactly SK_COUNT writes per run, addresses strictly ascending. o_sk_we is 0 at all other times.
- GEN -> DONE after i=4*SK_COUNT-1 (the last prekey, w_131).
- DONE, at E(4*SK_COUNT+2) (E134):
  - Registered outputs: o_done=1 for one cycle, o_busy=0, o_keys_valid=1.
  - Next edge: back to IDLE.
- i_start while GEN or DONE: ignored, no queueing.
- i_start and i_clear in the same IDLE cycle: i_clear wins; no start.
- i_clear, any state: next edge goes to IDLE, with o_busy=0, o_keys_valid=0, o_sk_we=0, no o_done. Partial RAM contents are don't-care.
- Reset mid-GEN: immediate abort; o_keys_valid=0. Restart requires a new i_start.
- New i_start from IDLE with o_keys_valid=1: o_keys_valid drops at E0 and stays low until the new o_done.
- Round engine must not read the RAM while o_keys_valid=0.

Test Plan:
- 256b all-zero key, i_start at E0:
  - Internal w_0 = 32'hBBCDCCF1.
  - o_sk_we at E5, E9, ..., E133 (33 pulses), addr 0..32.
  - o_done at E134 only; o_busy high E0..E133.
  - All 33 subkeys match the Serpent golden model.
- 128b key 00112233..EEFF with i_key_len=0 and garbage in i_key[255:128]: subkeys identical to a 256b run with i_key[128]=1 and upper bits 0. Repeat for 192b.
- i_start pulsed at E10 and E60 during a run: single run; timing identical to the first scenario; only 33 writes.
- i_clear asserted during GEN (after K3 written): next cycle o_busy=0, o_keys_valid=0, no further o_sk_we, no o_done. A following i_start produces a full correct schedule.
- i_rst_n low mid-GEN (async, between edges): all outputs 0 immediately; state IDLE after release.
- Back-to-back runs with keys A then B: o_keys_valid falls at B's E0; B's subkeys are correct. Simultaneous i_start and i_clear in IDLE: no run starts.

Source files
------------

// File: rtl/serpent_ks_seq.sv
// Serpent key schedule, one prekey per cycle: an 8-word sliding window feeds one shared ROL/XOR stage and one S-box stage.
// Subkey k is written at E(4k+5) after start at E0, o_done pulses at E(4*SK_COUNT+2); no backpressure; i_clear aborts.
module serpent_ks_seq #(
    parameter int          SK_COUNT = 33,
    parameter logic [31:0] PHI      = 32'h9e3779b9,
    parameter int          ROT      = 11
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [255:0] i_key,
    input  logic [1:0]   i_key_len,
    input  logic         i_clear,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_keys_valid,
    output logic         o_sk_we,
    output logic [5:0]   o_sk_addr,
    output logic [127:0] o_sk_data
);

    localparam logic [7:0] LAST_C = 8'(4 * SK_COUNT);

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4 },
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2 },
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1 },
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0 },
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6 }
    };

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t              state_q;
    logic [7:0][31:0]    win_q;     // [0] = w_{i-8} (oldest), [7] = w_{i-1} (newest)
    logic [7:0]          cnt_q;
    logic                busy_q, done_q, valid_q, sk_we_q;
    logic [5:0]          sk_addr_q;
    logic [127:0]        sk_data_q;

    logic [255:0]        pad_key;
    logic [31:0]         mix;
    logic [31:0]         w_new;
    logic [5:0]          kidx;
    logic [2:0]          sidx;
    logic [3:0]          nib;
    logic [3:0]          sb_out;
    logic [127:0]        sk_d;

    always_comb begin
        pad_key = i_key;
        case (i_key_len)
            2'd0:    pad_key = {127'd0, 1'b1, i_key[127:0]};
            2'd1:    pad_key = {63'd0, 1'b1, i_key[191:0]};
            default: pad_key = i_key;
        endcase
    end

    always_comb begin
        mix   = win_q[0] ^ win_q[3] ^ win_q[5] ^ win_q[7] ^ PHI ^ {24'd0, cnt_q};
        w_new = (mix << ROT) | (mix >> (32 - ROT));
    end

    // Window top four words are w_{4k..4k+3} on the cycle subkey k is written.
    always_comb begin
        kidx   = 6'((cnt_q >> 2) - 8'd1);
        sidx   = 3'd3 - kidx[2:0];
        sk_d   = '0;
        nib    = '0;
        sb_out = '0;
        for (int j = 0; j < 32; j++) begin
            nib    = {win_q[7][j], win_q[6][j], win_q[5][j], win_q[4][j]};
            sb_out = SBOX[sidx][nib];
            sk_d[j]      = sb_out[0];
            sk_d[32 + j] = sb_out[1];
            sk_d[64 + j] = sb_out[2];
            sk_d[96 + j] = sb_out[3];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            sk_we_q   <= 1'b0;
            sk_addr_q <= '0;
            sk_data_q <= '0;
        end else begin
            sk_we_q <= 1'b0;
            done_q  <= 1'b0;
            if (i_clear) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_start) begin
                            win_q   <= pad_key;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= GEN;
                        end
                    end
                    GEN: begin
                        if (cnt_q < LAST_C) begin
                            win_q <= {w_new, win_q[7:1]};
                        end
                        if (cnt_q >= 8'd4 && cnt_q[1:0] == 2'b00) begin
                            sk_we_q   <= 1'b1;
                            sk_addr_q <= kidx;
                            sk_data_q <= sk_d;
                        end
                        if (cnt_q == LAST_C) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_keys_valid = valid_q;
    assign o_sk_we      = sk_we_q;
    assign o_sk_addr    = sk_addr_q;
    assign o_sk_data    = sk_data_q;

endmodule

// File: tb/tb_serpent_ks_seq.sv
// Bench for serpent_ks_seq: random and directed keys against an array-based key-schedule model.
module tb_serpent_ks_seq;

    localparam int          SK  = 33;
    localparam logic [31:0] PHI = 32'h9e3779b9;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4 },
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2 },
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1 },
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0 },
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6 }
    };

    logic         i_clk;
    logic         i_rst_n;
    logic         i_start;
    logic [255:0] i_key;
    logic [1:0]   i_key_len;
    logic         i_clear;
    logic         o_busy, o_done, o_keys_valid, o_sk_we;
    logic [5:0]   o_sk_addr;
    logic [127:0] o_sk_data;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0]  mw [0:139];   // mw[j+8] holds prekey w_j
    logic [127:0] exp_sk [SK];

    serpent_ks_seq dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_key        (i_key),
        .i_key_len    (i_key_len),
        .i_clear      (i_clear),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_keys_valid (o_keys_valid),
        .o_sk_we      (o_sk_we),
        .o_sk_addr    (o_sk_addr),
        .o_sk_data    (o_sk_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_model(input logic [255:0] key, input logic [1:0] len);
        int          kl;
        int          sb;
        logic [255:0] kp;
        logic [31:0] x;
        logic [3:0]  nib;
        logic [3:0]  s;
        kl = (len == 2'd0) ? 128 : (len == 2'd1) ? 192 : 256;
        kp = key;
        for (int b = kl; b < 256; b++) kp[b] = 1'b0;
        if (kl < 256) kp[kl] = 1'b1;
        for (int m = 0; m < 8; m++) mw[m] = kp[32*m +: 32];
        for (int i = 0; i < 4*SK; i++) begin
            x = mw[i] ^ mw[i+3] ^ mw[i+5] ^ mw[i+7] ^ PHI ^ 32'(i);
            mw[i+8] = {x[20:0], x[31:21]};
        end
        for (int k = 0; k < SK; k++) begin
            sb = (3 - k + 64) % 8;
            exp_sk[k] = '0;
            for (int j = 0; j < 32; j++) begin
                nib = {mw[4*k+11][j], mw[4*k+10][j], mw[4*k+9][j], mw[4*k+8][j]};
                s   = SBOX[sb][nib];
                exp_sk[k][j]      = s[0];
                exp_sk[k][32 + j] = s[1];
                exp_sk[k][64 + j] = s[2];
                exp_sk[k][96 + j] = s[3];
            end
        end
    endtask

    // n is the edge index relative to the start edge E0; sampled 1 time unit after that edge.
    task automatic check_cycle(input int n);
        bit exp_we;
        exp_we = (n >= 5) && (n <= 4*SK + 1) && ((n - 5) % 4 == 0);
        chk("ctl{we,done,busy,valid}", 256'({o_sk_we, o_done, o_busy, o_keys_valid}),
            256'({exp_we, (n == 4*SK + 2), (n <= 4*SK + 1), (n >= 4*SK + 2)}));
        if (exp_we) begin
            chk("sk_addr", 256'(o_sk_addr), 256'((n - 5) / 4));
            chk("sk_data", 256'(o_sk_data), 256'(exp_sk[(n - 5) / 4]));
        end
    endtask

    task automatic start_edge(input logic [255:0] key, input logic [1:0] len);
        build_model(key, len);
        i_key     = key;
        i_key_len = len;
        i_start   = 1'b1;
        @(posedge i_clk); #1;
        i_start   = 1'b0;
    endtask

    task automatic run_and_check(input logic [255:0] key, input logic [1:0] len, input bit stray);
        start_edge(key, len);
        for (int n = 0; n <= 4*SK + 4; n++) begin
            if (n > 0) begin
                @(posedge i_clk); #1;
            end
            check_cycle(n);
            if (stray) i_start = (n == 9) || (n == 59);
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] r;
        for (int m = 0; m < 8; m++) r[32*m +: 32] = $urandom;
        return r;
    endfunction

    logic [255:0] key_a;

    initial begin
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_clear   = 1'b0;
        i_key     = '0;
        i_key_len = 2'd0;
        #12;
        chk("reset_outputs", 256'({o_busy, o_done, o_keys_valid, o_sk_we, o_sk_addr, o_sk_data}), 256'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // all-zero 256-bit key
        build_model(256'd0, 2'd2);
        chk("model_w0", 256'(mw[8]), 256'(32'hBBCDCCF1));
        run_and_check(256'd0, 2'd2, 1'b0);

        // short keys with garbage above the key length
        key_a = rand_key();
        key_a[127:0] = 128'h00112233445566778899aabbccddeeff;
        run_and_check(key_a, 2'd0, 1'b0);
        key_a = rand_key();
        key_a[191:0] = 192'h00112233445566778899aabbccddeeff0123456789abcdef;
        run_and_check(key_a, 2'd1, 1'b0);

        // stray starts mid-run are ignored
        run_and_check(256'd0, 2'd2, 1'b1);

        // clear after K3 has been written
        start_edge(rand_key(), 2'($urandom_range(0, 3)));
        for (int n = 0; n <= 18; n++) begin
            if (n > 0) begin
                @(posedge i_clk); #1;
            end
            check_cycle(n);
        end
        i_clear = 1'b1;
        for (int n = 19; n <= 4*SK + 6; n++) begin
            @(posedge i_clk); #1;
            i_clear = 1'b0;
            chk("after_clear", 256'({o_sk_we, o_done, o_busy, o_keys_valid}), 256'd0);
        end
        run_and_check(rand_key(), 2'($urandom_range(0, 3)), 1'b0);

        // asynchronous reset mid-generation
        start_edge(rand_key(), 2'd2);
        for (int n = 0; n <= 30; n++) begin
            if (n > 0) begin
                @(posedge i_clk); #1;
            end
            check_cycle(n);
        end
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_reset", 256'({o_busy, o_done, o_keys_valid, o_sk_we, o_sk_addr, o_sk_data}), 256'd0);
        @(posedge i_clk); #4;
        i_rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge i_clk); #1;
            chk("idle_after_reset", 256'({o_sk_we, o_done, o_busy, o_keys_valid}), 256'd0);
        end

        // back-to-back random runs, including the reserved length code
        for (int r = 0; r < 4; r++) begin
            run_and_check(rand_key(), 2'($urandom_range(0, 3)), 1'b0);
        end

        // start and clear together in IDLE: no run
        i_start = 1'b1;
        i_clear = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_clear = 1'b0;
        for (int n = 0; n < 8; n++) begin
            chk("start_with_clear", 256'({o_sk_we, o_done, o_busy, o_keys_valid}), 256'd0);
            @(posedge i_clk); #1;
        end

        run_and_check(rand_key(), 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
